// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  localparam int          PC_INCR              = 4;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/fetch_if.sv
// Fetch sequencer bus: control inputs, imem handshake and decode-side buffer.
// Perf counter outputs exist only when FETCH_PERF_EN is defined.
interface fetch_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic                     trigger;
  logic                     branch_taken;
  logic [ADDRESS_WIDTH-1:0] branch_target;
  logic                     imem_req;
  logic [ADDRESS_WIDTH-1:0] imem_addr;
  logic                     imem_ack;
  logic [DATA_WIDTH-1:0]    imem_rdata;
  logic                     instr_valid;
  logic                     instr_ready;
  logic [DATA_WIDTH-1:0]    instr;
  logic [ADDRESS_WIDTH-1:0] instr_pc;
  logic [ADDRESS_WIDTH-1:0] pc;
`ifdef FETCH_PERF_EN
  logic [31:0]              perf_fetch_cnt;
  logic [31:0]              perf_stall_cnt;
`endif

  modport master (
    input  trigger, branch_taken, branch_target, imem_ack, imem_rdata, instr_ready,
`ifdef FETCH_PERF_EN
    output perf_fetch_cnt, perf_stall_cnt,
`endif
    output imem_req, imem_addr, instr_valid, instr, instr_pc, pc
  );

  modport slave (
    output trigger, branch_taken, branch_target, imem_ack, imem_rdata, instr_ready,
`ifdef FETCH_PERF_EN
    input  perf_fetch_cnt, perf_stall_cnt,
`endif
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, pc
  );

endinterface

// File: rtl/fetch_buf.sv
// One-entry instruction/PC buffer between imem and decode.
// Flush beats load, load beats consume.
module fetch_buf #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load_i,
  input  logic                     flush_i,
  input  logic                     consume_i,
  input  logic [DATA_WIDTH-1:0]    data_i,
  input  logic [ADDRESS_WIDTH-1:0] pc_i,
  output logic                     valid_o,
  output logic [DATA_WIDTH-1:0]    instr_o,
  output logic [ADDRESS_WIDTH-1:0] pc_o
);

  logic                     valid_q;
  logic [DATA_WIDTH-1:0]    instr_q;
  logic [ADDRESS_WIDTH-1:0] pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      if (flush_i)
        valid_q <= 1'b0;
      else if (load_i)
        valid_q <= 1'b1;
      else if (consume_i)
        valid_q <= 1'b0;

      if (load_i && !flush_i) begin
        instr_q <= data_i;
        pc_q    <= pc_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: PC register, imem req/ack FSM and one-entry output buffer.
// Define FETCH_PERF_EN to add fetch/stall performance counters.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR  = ADDRESS_WIDTH'(DEFAULT_RESET_VECTOR)
) (
  input logic    clk,
  input logic    rst_n,
  fetch_if.master bus
);

  fetch_state_t             state_q;
  logic [ADDRESS_WIDTH-1:0] pc_q;
  logic [ADDRESS_WIDTH-1:0] pc_d;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic                     req_q;
  logic [ADDRESS_WIDTH-1:0] pc_inc;
  logic [ADDRESS_WIDTH-1:0] tgt_aligned;
  logic                     issue_ok;
  logic                     ack_live;
  logic                     reissue;

  assign tgt_aligned = bus.branch_target & ~ADDRESS_WIDTH'(3);
  assign pc_inc      = pc_q + ADDRESS_WIDTH'(PC_INCR);
  assign issue_ok    = bus.trigger & (~bus.instr_valid | bus.instr_ready);
  assign ack_live    = (state_q == REQ) & bus.imem_ack & ~bus.branch_taken;
  // A redirect flushes the buffer, so only trigger gates the follow-on request.
  assign reissue     = bus.branch_taken ? bus.trigger : issue_ok;

  always_comb begin
    pc_d = pc_q;
    if (bus.branch_taken)
      pc_d = tgt_aligned;
    else if (ack_live)
      pc_d = pc_inc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_VECTOR;
      addr_q  <= '0;
      req_q   <= 1'b0;
    end else begin
      pc_q <= pc_d;
      case (state_q)
        IDLE: begin
          if (issue_ok) begin
            state_q <= REQ;
            req_q   <= 1'b1;
            addr_q  <= pc_d;
          end
        end
        REQ: begin
          if (bus.imem_ack) begin
            if (reissue) begin
              state_q <= REQ;
              req_q   <= 1'b1;
              addr_q  <= pc_d;
            end else begin
              state_q <= IDLE;
              req_q   <= 1'b0;
            end
          end else if (bus.branch_taken) begin
            // Bus cannot abort: keep old address until the stale ack arrives.
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (bus.imem_ack) begin
            if (bus.trigger) begin
              state_q <= REQ;
              req_q   <= 1'b1;
              addr_q  <= pc_d;
            end else begin
              state_q <= IDLE;
              req_q   <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req  = req_q;
  assign bus.imem_addr = addr_q;
  assign bus.pc        = pc_q;

  fetch_buf #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH)
  ) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (ack_live),
    .flush_i  (bus.branch_taken),
    .consume_i(bus.instr_valid & bus.instr_ready),
    .data_i   (bus.imem_rdata),
    .pc_i     (pc_q),
    .valid_o  (bus.instr_valid),
    .instr_o  (bus.instr),
    .pc_o     (bus.instr_pc)
  );

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_q + 32'(ack_live);
      stall_cnt_q <= stall_cnt_q + 32'(bus.instr_valid & ~bus.instr_ready);
    end
  end

  assign bus.perf_fetch_cnt = fetch_cnt_q;
  assign bus.perf_stall_cnt = stall_cnt_q;
`endif

endmodule
